// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Imported by the prescaler and the scan multiplexer.
package seg_pkg;

    localparam int N_DIGITS_DEFAULT = 8;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [N_DIGITS_DEFAULT-1:0] AN_ALL_OFF = '1;

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: counts 0..DIV-1 and flags the last cycle.
// slot_tick is combinational from the count register.
module scan_prescaler
    import seg_pkg::*;
#(
    parameter int DIV = 100000,
    localparam int CW = cnt_width(DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] cnt,
    output logic          slot_tick
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    if (DIV < 2) begin : g_bad_div
        $error("scan_prescaler: DIV must be 2 or more");
    end

    // Wrap at DIV-1, otherwise count up.
    always_comb begin
        slot_tick = (cnt_q == CW'(DIV - 1));
        cnt_d     = slot_tick ? '0 : cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-seg digit scanner with double-buffered data.
// Staging is copied to active only at frame boundaries.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int N_DIGITS = N_DIGITS_DEFAULT,
    parameter int DIV      = 100000,
    parameter int GAP      = 2000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   en_in,
    input  logic                  load,
    output logic [3:0]            num_out,
    output logic                  dp_n_out,
    output logic [N_DIGITS-1:0]   an_out,
    output logic                  frame_done
);

    localparam int CW = cnt_width(DIV);
    localparam int IW = cnt_width(N_DIGITS);

    if (DIV < 2 || GAP < 0 || GAP >= DIV) begin : g_bad_par
        $error("seg_scan_mux: need DIV >= 2 and 0 <= GAP < DIV");
    end

    logic [CW-1:0] cnt;
    logic          slot_tick;

    scan_prescaler #(.DIV(DIV)) u_presc (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt       (cnt),
        .slot_tick (slot_tick)
    );

    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] stg_data_q, stg_data_d;
    logic [N_DIGITS-1:0]   stg_dp_q, stg_dp_d;
    logic [N_DIGITS-1:0]   stg_en_q, stg_en_d;
    logic                  pending_q, pending_d;
    logic [4*N_DIGITS-1:0] act_data_q, act_data_d;
    logic [N_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [N_DIGITS-1:0]   act_en_q, act_en_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [3:0]            num_q, num_d;
    logic                  dp_n_q, dp_n_d;
    logic                  fd_q, fd_d;

    logic frame_bnd;
    logic [3:0] nib_sel;
    logic dp_sel;
    logic en_sel;
    logic lit;

    // Digit index, buffer handoff and next output values.
    always_comb begin
        frame_bnd  = slot_tick && (idx_q == IW'(N_DIGITS - 1));
        idx_d      = idx_q;
        stg_data_d = stg_data_q;
        stg_dp_d   = stg_dp_q;
        stg_en_d   = stg_en_q;
        pending_d  = pending_q;
        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        act_en_d   = act_en_q;
        nib_sel    = '0;
        dp_sel     = 1'b0;
        en_sel     = 1'b0;

        if (slot_tick) begin
            idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        if (load) begin
            stg_data_d = data_in;
            stg_dp_d   = dp_in;
            stg_en_d   = en_in;
            pending_d  = 1'b1;
        end

        // A load on the boundary itself goes straight to active.
        if (frame_bnd) begin
            if (load) begin
                act_data_d = data_in;
                act_dp_d   = dp_in;
                act_en_d   = en_in;
                pending_d  = 1'b0;
            end else if (pending_q) begin
                act_data_d = stg_data_q;
                act_dp_d   = stg_dp_q;
                act_en_d   = stg_en_q;
                pending_d  = 1'b0;
            end
        end

        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nib_sel = act_data_q[4*k +: 4];
                dp_sel  = act_dp_q[k];
                en_sel  = act_en_q[k];
            end
        end

        lit = (int'(cnt) >= GAP) && en_sel;
        for (int k = 0; k < N_DIGITS; k++) begin
            an_d[k] = !(lit && (idx_q == IW'(k)));
        end
        num_d  = nib_sel;
        dp_n_d = lit ? ~dp_sel : 1'b1;
        fd_d   = frame_bnd;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            stg_data_q <= '0;
            stg_dp_q   <= '0;
            stg_en_q   <= '0;
            pending_q  <= 1'b0;
            act_data_q <= '0;
            act_dp_q   <= '0;
            act_en_q   <= '0;
            an_q       <= '1;
            num_q      <= '0;
            dp_n_q     <= 1'b1;
            fd_q       <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            stg_data_q <= stg_data_d;
            stg_dp_q   <= stg_dp_d;
            stg_en_q   <= stg_en_d;
            pending_q  <= pending_d;
            act_data_q <= act_data_d;
            act_dp_q   <= act_dp_d;
            act_en_q   <= act_en_d;
            an_q       <= an_d;
            num_q      <= num_d;
            dp_n_q     <= dp_n_d;
            fd_q       <= fd_d;
        end
    end

    assign an_out     = an_q;
    assign num_out    = num_q;
    assign dp_n_out   = dp_n_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux with a time-based reference model.
// Expected outputs come from the elapsed cycle count since reset.
module tb_seg_scan_mux;

    localparam int N   = 8;
    localparam int DIV = 4;
    localparam int GAP = 1;
    localparam int FR  = N * DIV;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   data_in = '0;
    logic [7:0]    dp_in = '0;
    logic [7:0]    en_in = '0;
    logic          load = 1'b0;
    logic [3:0]    num_out;
    logic          dp_n_out;
    logic [7:0]    an_out;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    seg_scan_mux #(.N_DIGITS(N), .DIV(DIV), .GAP(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .en_in      (en_in),
        .load       (load),
        .num_out    (num_out),
        .dp_n_out   (dp_n_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: slot position is derived from cycles since reset.
    int          m_t;
    logic [31:0] m_sd, m_ad;
    logic [7:0]  m_sp, m_se, m_ap, m_ae;
    logic        m_pend;
    logic [7:0]  e_an;
    logic [3:0]  e_num;
    logic        e_dp, e_fd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= 0;
            m_sd <= '0; m_sp <= '0; m_se <= '0;
            m_ad <= '0; m_ap <= '0; m_ae <= '0;
            m_pend <= 1'b0;
            e_an <= 8'hFF; e_num <= '0; e_dp <= 1'b1; e_fd <= 1'b0;
        end else begin : step
            automatic int c = m_t % DIV;
            automatic int i = (m_t / DIV) % N;
            automatic bit lit = (c >= GAP) && m_ae[i];
            automatic bit bnd = (c == DIV - 1) && (i == N - 1);
            e_an  <= lit ? ~(8'd1 << i) : 8'hFF;
            e_num <= 4'((m_ad >> (4 * i)) & 32'hF);
            e_dp  <= lit ? ~m_ap[i] : 1'b1;
            e_fd  <= bnd;
            if (load) begin
                m_sd <= data_in; m_sp <= dp_in; m_se <= en_in;
                m_pend <= 1'b1;
            end
            if (bnd && load) begin
                m_ad <= data_in; m_ap <= dp_in; m_ae <= en_in;
                m_pend <= 1'b0;
            end else if (bnd && m_pend) begin
                m_ad <= m_sd; m_ap <= m_sp; m_ae <= m_se;
                m_pend <= 1'b0;
            end
            m_t <= m_t + 1;
        end
    end

    task automatic wait_frame_done(input string tag);
        bit seen = 0;
        for (int n = 0; n < 3 * FR && !seen; n++) begin
            @(negedge clk);
            seen = frame_done;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s frame_done timeout got 0 exp 1", tag);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (an_out !== 8'hFF || num_out !== 4'h0 || dp_n_out !== 1'b1
            || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold an=%h num=%h dp=%b fd=%b exp FF 0 1 0",
                     an_out, num_out, dp_n_out, frame_done);
        end
        rst_n = 1'b1;
        for (int j = 1; j <= FR; j++) begin
            @(negedge clk);
            checks++;
            if (an_out !== 8'hFF || num_out !== 4'h0 || dp_n_out !== 1'b1) begin
                errors++;
                $display("FAIL reset_blank j=%0d an=%h num=%h dp=%b exp FF 0 1",
                         j, an_out, num_out, dp_n_out);
            end
            checks++;
            if (frame_done !== (j == FR)) begin
                errors++;
                $display("FAIL reset_fd j=%0d got %b exp %b",
                         j, frame_done, (j == FR));
            end
        end
    endtask

    task automatic test_frame_sweep();
        data_in = 32'h76543210; en_in = 8'hFF; dp_in = 8'h01; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame_done("sweep");
        for (int j = 1; j <= FR; j++) begin
            automatic int c = (j - 1) % DIV;
            automatic int k = (j - 1) / DIV;
            automatic logic [7:0] xa = (c < GAP) ? 8'hFF : ~(8'd1 << k);
            automatic logic xd = (c >= GAP && k == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (an_out !== xa || num_out !== 4'(k) || dp_n_out !== xd) begin
                errors++;
                $display("FAIL sweep j=%0d an=%h num=%h dp=%b exp %h %h %b",
                         j, an_out, num_out, dp_n_out, xa, 4'(k), xd);
            end
        end
    endtask

    task automatic test_blanking();
        data_in = 32'h76543210; en_in = 8'b1010_1010; dp_in = 8'h00;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_frame_done("blank");
        for (int j = 1; j <= FR; j++) begin
            automatic int c = (j - 1) % DIV;
            automatic int k = (j - 1) / DIV;
            automatic logic [7:0] xa =
                (c < GAP || (k % 2) == 0) ? 8'hFF : ~(8'd1 << k);
            @(negedge clk);
            checks++;
            if (an_out !== xa || num_out !== 4'(k)) begin
                errors++;
                $display("FAIL blank j=%0d an=%h num=%h exp %h %h",
                         j, an_out, num_out, xa, 4'(k));
            end
        end
    endtask

    task automatic test_tear_free();
        wait_frame_done("tear_sync");
        data_in = 32'h76543210; en_in = 8'hFF; dp_in = 8'h00;
        repeat (10) @(negedge clk);
        data_in = 32'h11111111; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int j = 12; j <= FR; j++) begin
            @(negedge clk);
            checks++;
            if (num_out !== 4'((j - 1) / DIV) || frame_done !== (j == FR)) begin
                errors++;
                $display("FAIL tear_old j=%0d num=%h fd=%b exp %h %b",
                         j, num_out, frame_done, 4'((j - 1) / DIV), (j == FR));
            end
        end
        for (int j = 1; j <= FR; j++) begin
            @(negedge clk);
            checks++;
            if (num_out !== 4'h1 || an_out !== e_an) begin
                errors++;
                $display("FAIL tear_new j=%0d num=%h an=%h exp 1 %h",
                         j, num_out, an_out, e_an);
            end
        end
    endtask

    task automatic test_boundary_load();
        int n = 0;
        while ((m_t % FR) != FR - 1 && n < 2 * FR) begin
            @(negedge clk);
            n++;
        end
        data_in = 32'hAAAAAAAA; en_in = 8'hFF; dp_in = 8'h00; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || dut.pending_q !== 1'b0) begin
            errors++;
            $display("FAIL bnd_load fd=%b pend=%b exp 1 0",
                     frame_done, dut.pending_q);
        end
        for (int j = 1; j <= FR; j++) begin
            @(negedge clk);
            checks++;
            if (num_out !== 4'hA || an_out !== e_an) begin
                errors++;
                $display("FAIL bnd_frame j=%0d num=%h an=%h exp A %h",
                         j, num_out, an_out, e_an);
            end
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        while (an_out !== 8'hF7 && n < 2 * FR) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (an_out !== 8'hF7) begin
            errors++;
            $display("FAIL arst_pre an=%h exp F7", an_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (an_out !== 8'hFF || num_out !== 4'h0 || dp_n_out !== 1'b1
            || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL arst_now an=%h num=%h dp=%b fd=%b exp FF 0 1 0",
                     an_out, num_out, dp_n_out, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j <= FR; j++) begin
            @(negedge clk);
            checks++;
            if (an_out !== 8'hFF || frame_done !== (j == FR)) begin
                errors++;
                $display("FAIL arst_after j=%0d an=%h fd=%b exp FF %b",
                         j, an_out, frame_done, (j == FR));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6 * FR; n++) begin
            load = ($urandom_range(0, 4) == 0);
            data_in = $urandom;
            dp_in = 8'($urandom);
            en_in = 8'($urandom);
            @(negedge clk);
            checks++;
            if (an_out !== e_an || num_out !== e_num || dp_n_out !== e_dp
                || frame_done !== e_fd || dut.pending_q !== m_pend) begin
                errors++;
                $display("FAIL rand n=%0d an=%h num=%h dp=%b fd=%b pend=%b exp %h %h %b %b %b",
                         n, an_out, num_out, dp_n_out, frame_done,
                         dut.pending_q, e_an, e_num, e_dp, e_fd, m_pend);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame_sweep();
        test_blanking();
        test_tear_free();
        test_boundary_load();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
